// File: rtl/instruction_loader.sv
// UART byte stream to instruction memory loader: assembles big-endian 32-bit words,
// writes them from address 0 upward, and stops on a halt word or a full memory.
module instruction_loader #(
  parameter int unsigned       SIZE       = 32,
  parameter int unsigned       MEM_SIZE   = 64,
  parameter int unsigned       ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter logic [SIZE-1:0]   HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_writing_instruction_mem,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int unsigned ASM_W  = SIZE - 8;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  // Only the first three bytes are held; the fourth goes straight into the write data.
  logic [ASM_W-1:0]      asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [SIZE-1:0]       wdata_q, wdata_d;
  logic                  writing_q, writing_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      wcount_q, wcount_d;
  logic [SIZE-1:0]       full_word;

  assign full_word = {asm_q, i_rx_data};

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      writing_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      writing_q  <= writing_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wcount_q   <= wcount_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    writing_d  = writing_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    wcount_d   = wcount_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d    = RECV;
          addr_d     = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          wcount_d   = '0;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          writing_d  = 1'b1;
        end
      end

      RECV: begin
        if (i_rx_done) begin
          asm_d      = full_word[ASM_W-1:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d  = WRITE;
            we_d     = 1'b1;
            waddr_d  = addr_q;
            wdata_d  = full_word;
            wcount_d = wcount_q + CNT_W'(1);
          end
        end
      end

      WRITE: begin
        if (wdata_q == HALT_WORD || addr_q == LAST_ADDR) begin
          state_d   = DONE;
          done_d    = 1'b1;
          writing_d = 1'b0;
          ovf_d     = (wdata_q != HALT_WORD);
        end else begin
          state_d = RECV;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          // A byte landing during the write strobe starts the next word.
          if (i_rx_done) begin
            asm_d      = full_word[ASM_W-1:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_inst_write_enable       = we_q;
  assign o_write_addr              = waddr_q;
  assign o_write_data              = wdata_q;
  assign o_writing_instruction_mem = writing_q;
  assign o_done                    = done_q;
  assign o_overflow                = ovf_q;
  assign o_word_count              = wcount_q;

endmodule
